// File: rtl/pwm_mixer_n_pkg.sv
// Shared definitions for the quadrature-encoder PWM mixer.
// Holds the legal parameter ranges, the reset values used by the debouncers and the
// level registers, and a helper that validates a parameter set at elaboration.
package pwm_mixer_n_pkg;

  localparam int unsigned NUM_CH_MIN   = 1;
  localparam int unsigned NUM_CH_MAX   = 8;
  localparam int unsigned WIDTH_MIN    = 4;
  localparam int unsigned WIDTH_MAX    = 12;
  localparam int unsigned HIST_LEN_MIN = 2;
  localparam int unsigned HIST_LEN_MAX = 16;

  // Debounced encoder lines and their histories come out of reset low.
  localparam logic        DEB_RESET   = 1'b0;
  // Channel level (and duty shadow) value after reset.
  localparam int unsigned LEVEL_RESET = 0;

  function automatic bit params_ok(input int unsigned num_ch, input int unsigned width,
                                   input int unsigned hist_len, input int unsigned saturate,
                                   input int unsigned step);
    bit ok;
    ok = (num_ch >= NUM_CH_MIN) && (num_ch <= NUM_CH_MAX) &&
         (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
         (hist_len >= HIST_LEN_MIN) && (hist_len <= HIST_LEN_MAX) &&
         (saturate <= 1) && (step >= 1);
    if (ok) ok = (step <= (32'd1 << (width - 1)));
    return ok;
  endfunction

endpackage

// File: rtl/mixer_channel.sv
// One encoder-to-PWM channel.
// Synchronises and debounces the A/B quadrature lines, steps a level register on each
// debounced A rising edge (direction from debounced B), snapshots the level into a duty
// shadow at the period boundary, and compares the shared counter against that duty.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   enc_a, enc_b     raw quadrature inputs (asynchronous to clk)
//   cnt              shared period counter
//   load             high in the cycle the counter sits at its maximum
//   pwm_out          registered PWM output
//   level_out        live level register
module mixer_channel
  import pwm_mixer_n_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned HIST_LEN = 8,
  parameter int unsigned SATURATE = 1,
  parameter int unsigned STEP     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic [WIDTH-1:0] cnt,
  input  logic             load,
  output logic             pwm_out,
  output logic [WIDTH-1:0] level_out
);

  localparam logic [WIDTH:0]   STEP_W    = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0] LEVEL_MAX = '1;
  localparam logic [WIDTH-1:0] LEVEL_RST = WIDTH'(LEVEL_RESET);

  logic [1:0]          a_sync_q, b_sync_q;
  logic [HIST_LEN-1:0] a_hist_q, b_hist_q;
  logic                a_deb_q, a_deb_d, b_deb_q, b_deb_d;
  logic                a_prev_q;
  logic [WIDTH-1:0]    level_q, level_d, duty_q, duty_d;
  logic [WIDTH:0]      sum, diff;
  logic                pwm_q;

  // Debounce: follow the line only once the whole history agrees, otherwise hold.
  always_comb begin
    a_deb_d = a_deb_q;
    if (&a_hist_q) a_deb_d = 1'b1;
    else if (~|a_hist_q) a_deb_d = 1'b0;
    b_deb_d = b_deb_q;
    if (&b_hist_q) b_deb_d = 1'b1;
    else if (~|b_hist_q) b_deb_d = 1'b0;
  end

  // One extra bit catches overflow on add and borrow on subtract.
  always_comb begin
    sum     = {1'b0, level_q} + STEP_W;
    diff    = {1'b0, level_q} - STEP_W;
    level_d = level_q;
    if (a_deb_q && !a_prev_q) begin
      if (!b_deb_q) level_d = ((SATURATE != 0) && sum[WIDTH])  ? LEVEL_MAX : sum[WIDTH-1:0];
      else          level_d = ((SATURATE != 0) && diff[WIDTH]) ? '0        : diff[WIDTH-1:0];
    end
    // Shadow takes the pre-update level, so a coincident step lands next period.
    duty_d = load ? level_q : duty_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sync_q <= {2{DEB_RESET}};
      b_sync_q <= {2{DEB_RESET}};
      a_hist_q <= {HIST_LEN{DEB_RESET}};
      b_hist_q <= {HIST_LEN{DEB_RESET}};
      a_deb_q  <= DEB_RESET;
      b_deb_q  <= DEB_RESET;
      a_prev_q <= DEB_RESET;
      level_q  <= LEVEL_RST;
      duty_q   <= LEVEL_RST;
      pwm_q    <= 1'b0;
    end else begin
      a_sync_q <= {a_sync_q[0], enc_a};
      b_sync_q <= {b_sync_q[0], enc_b};
      a_hist_q <= {a_hist_q[HIST_LEN-2:0], a_sync_q[1]};
      b_hist_q <= {b_hist_q[HIST_LEN-2:0], b_sync_q[1]};
      a_deb_q  <= a_deb_d;
      b_deb_q  <= b_deb_d;
      a_prev_q <= a_deb_q;
      level_q  <= level_d;
      duty_q   <= duty_d;
      pwm_q    <= (cnt < duty_q);
    end
  end

  assign pwm_out   = pwm_q;
  assign level_out = level_q;

endmodule

// File: rtl/pwm_mixer_n.sv
// Multi-channel rotary-encoder to PWM mixer.
// Each channel turns quadrature detents into a level; all channels share one free-running
// period counter and emit a registered PWM whose duty is that level, updated only at the
// period boundary.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   enc_a, enc_b    quadrature inputs, one bit per channel
//   pwm_out         registered PWM per channel
//   level_out       live levels, channel i at [i*WIDTH +: WIDTH]
//   sync            one-cycle pulse on the first cycle of each period
//   io_oeb          pad output enables, tied low
module pwm_mixer_n
  import pwm_mixer_n_pkg::*;
#(
  parameter int unsigned NUM_CH   = 3,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned HIST_LEN = 8,
  parameter int unsigned SATURATE = 1,
  parameter int unsigned STEP     = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       enc_a,
  input  logic [NUM_CH-1:0]       enc_b,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic [NUM_CH*WIDTH-1:0] level_out,
  output logic                    sync,
  output logic [NUM_CH:0]         io_oeb
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  if (!params_ok(NUM_CH, WIDTH, HIST_LEN, SATURATE, STEP)) begin : g_bad_params
    $error("pwm_mixer_n: parameter out of range");
  end

  logic [WIDTH-1:0] cnt_q;
  logic             sync_q;
  logic             load;

  assign load = (cnt_q == CNT_MAX);

  // Outputs are registered from the counter, so sync lines up with the first PWM
  // cycle that uses the freshly loaded duty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      sync_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_q + WIDTH'(1);
      sync_q <= (cnt_q == '0);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    mixer_channel #(
      .WIDTH    (WIDTH),
      .HIST_LEN (HIST_LEN),
      .SATURATE (SATURATE),
      .STEP     (STEP)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .enc_a     (enc_a[i]),
      .enc_b     (enc_b[i]),
      .cnt       (cnt_q),
      .load      (load),
      .pwm_out   (pwm_out[i]),
      .level_out (level_out[i*WIDTH +: WIDTH])
    );
  end

  assign sync   = sync_q;
  assign io_oeb = '0;

endmodule

// File: tb/tb_pwm_mixer_n.sv
// Bench for pwm_mixer_n: three instances (defaults; 4ch/6-bit/step 4/wrap; 1ch 8-bit wrap)
// driven with randomized quadrature detents and compared against an arithmetic level model.
module tb_pwm_mixer_n;

  localparam int HIST = 8;

  logic clk = 1'b0;
  logic rst0 = 1'b0, rst1 = 1'b0, rst2 = 1'b0;
  logic [2:0] a0 = '0, b0 = '0, pwm0;
  logic [23:0] lvlo0;
  logic sync0;
  logic [3:0] oeb0;
  logic [3:0] a1 = '0, b1 = '0, pwm1;
  logic [23:0] lvlo1;
  logic sync1;
  logic [4:0] oeb1;
  logic [0:0] a2 = '0, b2 = '0, pwm2;
  logic [7:0] lvlo2;
  logic sync2;
  logic [1:0] oeb2;

  int n_pass = 0;
  int n_total = 0;

  // Model configuration and state, indexed by instance.
  int wdt[3] = '{8, 6, 8};
  int stp[3] = '{1, 4, 1};
  int sat[3] = '{1, 0, 0};
  int nch[3] = '{3, 4, 1};
  int lvl[3][8];

  always #5 clk = ~clk;

  pwm_mixer_n u_dut0 (
    .clk(clk), .reset(rst0), .enc_a(a0), .enc_b(b0), .pwm_out(pwm0),
    .level_out(lvlo0), .sync(sync0), .io_oeb(oeb0)
  );

  pwm_mixer_n #(.NUM_CH(4), .WIDTH(6), .HIST_LEN(8), .SATURATE(0), .STEP(4)) u_dut1 (
    .clk(clk), .reset(rst1), .enc_a(a1), .enc_b(b1), .pwm_out(pwm1),
    .level_out(lvlo1), .sync(sync1), .io_oeb(oeb1)
  );

  pwm_mixer_n #(.NUM_CH(1), .WIDTH(8), .HIST_LEN(8), .SATURATE(0), .STEP(1)) u_dut2 (
    .clk(clk), .reset(rst2), .enc_a(a2), .enc_b(b2), .pwm_out(pwm2),
    .level_out(lvlo2), .sync(sync2), .io_oeb(oeb2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_total++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
  endtask

  function automatic int get_level(input int d, input int ch);
    case (d)
      0:       return int'(lvlo0[ch*8 +: 8]);
      1:       return int'(lvlo1[ch*6 +: 6]);
      default: return int'(lvlo2);
    endcase
  endfunction

  function automatic logic get_pwm(input int d, input int ch);
    case (d)
      0:       return pwm0[ch];
      1:       return pwm1[ch];
      default: return pwm2[0];
    endcase
  endfunction

  function automatic logic get_sync(input int d);
    case (d)
      0:       return sync0;
      1:       return sync1;
      default: return sync2;
    endcase
  endfunction

  // Level arithmetic straight from the rules: clamp or wrap modulo 2^WIDTH.
  function automatic int step_model(input int cur, input bit up, input int d);
    int m = 1 << wdt[d];
    int n = up ? cur + stp[d] : cur - stp[d];
    if (sat[d] != 0) begin
      if (n < 0) n = 0;
      if (n > m - 1) n = m - 1;
    end else begin
      n = ((n % m) + m) % m;
    end
    return n;
  endfunction

  task automatic apply_model(input int d, input logic [7:0] mask, input bit up);
    for (int i = 0; i < nch[d]; i++) if (mask[i]) lvl[d][i] = step_model(lvl[d][i], up, d);
  endtask

  task automatic set_ab(input int d, input logic [7:0] mask, input logic pa, input logic pb);
    for (int i = 0; i < nch[d]; i++) begin
      if (mask[i]) begin
        case (d)
          0:       begin a0[i] = pa; b0[i] = pb; end
          1:       begin a1[i] = pa; b1[i] = pb; end
          default: begin a2[0] = pa; b2[0] = pb; end
        endcase
      end
    end
  endtask

  task automatic hold_ab(input int d, input logic [7:0] mask, input logic pa, input logic pb,
                         input int n);
    set_ab(d, mask, pa, pb);
    repeat (n) @(negedge clk);
  endtask

  // One full quadrature detent; forward means B low when A rises.
  task automatic turn(input int d, input logic [7:0] mask, input bit fwd);
    int h = int'($urandom_range(HIST + 6, HIST + 3));
    if (fwd) begin
      hold_ab(d, mask, 1'b1, 1'b0, h);
      hold_ab(d, mask, 1'b1, 1'b1, h);
      hold_ab(d, mask, 1'b0, 1'b1, h);
      hold_ab(d, mask, 1'b0, 1'b0, h);
    end else begin
      hold_ab(d, mask, 1'b0, 1'b1, h);
      hold_ab(d, mask, 1'b1, 1'b1, h);
      hold_ab(d, mask, 1'b1, 1'b0, h);
      hold_ab(d, mask, 1'b0, 1'b0, h);
    end
    apply_model(d, mask, fwd);
  endtask

  task automatic check_levels(input int d, input string tag);
    for (int i = 0; i < nch[d]; i++)
      chk($sformatf("%s_d%0d_ch%0d", tag, d, i), get_level(d, i), lvl[d][i]);
  endtask

  task automatic wait_sync(input int d);
    for (int i = 0; i < (1 << wdt[d]) + 8 && get_sync(d) !== 1'b1; i++) @(negedge clk);
    chk($sformatf("d%0d_sync_seen", d), get_sync(d), 1);
  endtask

  // Starting on a sync sample, walk one period: channel ch must be high for exactly the
  // first duty[ch] cycles and sync only on the first; the next period must open with sync.
  task automatic check_period(input int d, input int duty [8]);
    int p = 1 << wdt[d];
    int bad[8];
    int hi[8];
    int bad_sync = 0;
    logic want;
    for (int ch = 0; ch < 8; ch++) begin bad[ch] = 0; hi[ch] = 0; end
    for (int k = 0; k < p; k++) begin
      for (int ch = 0; ch < nch[d]; ch++) begin
        want = (k < duty[ch]);
        if (get_pwm(d, ch) !== want) bad[ch]++;
        if (get_pwm(d, ch) === 1'b1) hi[ch]++;
      end
      if (get_sync(d) !== (k == 0)) bad_sync++;
      @(negedge clk);
    end
    for (int ch = 0; ch < nch[d]; ch++) begin
      chk($sformatf("d%0d_ch%0d_pwm_shape", d, ch), bad[ch], 0);
      chk($sformatf("d%0d_ch%0d_pwm_high", d, ch), hi[ch], duty[ch]);
    end
    chk($sformatf("d%0d_sync_spacing", d), bad_sync, 0);
    chk($sformatf("d%0d_sync_period", d), get_sync(d), 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int old;
    int n;
    int duty[8];
    for (int d = 0; d < 3; d++) for (int i = 0; i < 8; i++) lvl[d][i] = 0;
    repeat (3) @(negedge clk);

    // Instance 0: defaults, saturating.
    chk("d0_rst_pwm", pwm0, 0);
    chk("d0_rst_level", lvlo0, 0);
    chk("d0_rst_sync", sync0, 0);
    chk("d0_oeb", oeb0, 0);
    rst0 = 1'b1;
    @(negedge clk);
    chk("d0_first_sync", sync0, 1);
    check_period(0, lvl[0]);

    repeat (5) turn(0, 8'b001, 1'b1);
    chk("d0_ch0_fwd5", get_level(0, 0), 5);
    check_levels(0, "fwd5");
    wait_sync(0);
    check_period(0, lvl[0]);

    // Short A glitches and lone B activity must leave ch1 untouched.
    repeat ($urandom_range(6, 3)) begin
      hold_ab(0, 8'b010, 1'b1, 1'b0, 3);
      hold_ab(0, 8'b010, 1'b0, 1'b0, int'($urandom_range(3, 1)));
    end
    hold_ab(0, 8'b010, 1'b0, 1'b0, 20);
    hold_ab(0, 8'b010, 1'b0, 1'b1, HIST + 5);
    hold_ab(0, 8'b010, 1'b0, 1'b0, HIST + 5);
    chk("d0_ch1_glitch", get_level(0, 1), 0);

    repeat (8) turn(0, 8'($urandom_range(7, 1)), 1'($urandom_range(1, 0)));
    check_levels(0, "rand");

    // Measure edge-to-level latency on ch0, then land a step on the boundary cycle.
    lat = 0;
    set_ab(0, 8'b001, 1'b1, 1'b0);
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(negedge clk);
      if (get_level(0, 0) != lvl[0][0]) lat = i;
    end
    apply_model(0, 8'b001, 1'b1);
    chk("d0_latency_found", (lat > 0), 1);
    hold_ab(0, 8'b001, 1'b1, 1'b0, HIST + 3);
    hold_ab(0, 8'b001, 1'b1, 1'b1, HIST + 3);
    hold_ab(0, 8'b001, 1'b0, 1'b1, HIST + 3);
    hold_ab(0, 8'b001, 1'b0, 1'b0, HIST + 3);
    if (lat > 1) begin
      wait_sync(0);
      old = lvl[0][0];
      repeat (255 - lat) @(negedge clk);
      set_ab(0, 8'b001, 1'b1, 1'b0);
      repeat (lat - 1) @(negedge clk);
      chk("d0_pre_boundary", get_level(0, 0), old);
      apply_model(0, 8'b001, 1'b1);
      @(negedge clk);
      chk("d0_boundary_step", get_level(0, 0), lvl[0][0]);
      @(negedge clk);
      duty = lvl[0];
      duty[0] = old;
      check_period(0, duty);
      check_period(0, lvl[0]);
      hold_ab(0, 8'b001, 1'b1, 1'b1, HIST + 3);
      hold_ab(0, 8'b001, 1'b0, 1'b1, HIST + 3);
      hold_ab(0, 8'b001, 1'b0, 1'b0, HIST + 3);
    end

    // Saturation on ch2 at both ends.
    n = lvl[0][2];
    repeat (n) turn(0, 8'b100, 1'b0);
    repeat (3) turn(0, 8'b100, 1'b0);
    chk("d0_sat_low", get_level(0, 2), 0);
    repeat (254) turn(0, 8'b100, 1'b1);
    chk("d0_at_254", get_level(0, 2), 254);
    repeat (3) turn(0, 8'b100, 1'b1);
    chk("d0_sat_high", get_level(0, 2), 255);
    wait_sync(0);
    check_period(0, lvl[0]);
    rst0 = 1'b0;

    // Instance 1: 4 channels, 6-bit, step 4, wrapping.
    chk("d1_rst_level", lvlo1, 0);
    chk("d1_rst_pwm", pwm1, 0);
    rst1 = 1'b1;
    @(negedge clk);
    chk("d1_first_sync", sync1, 1);
    turn(1, 8'h0F, 1'b1);
    for (int i = 0; i < 4; i++) chk($sformatf("d1_ch%0d_is4", i), get_level(1, i), 4);
    wait_sync(1);
    check_period(1, lvl[1]);
    chk("d1_pwm_before_rst", pwm1, 4'hF);
    #2 rst1 = 1'b0;
    #1;
    chk("d1_async_pwm", pwm1, 0);
    chk("d1_async_level", lvlo1, 0);
    chk("d1_async_sync", sync1, 0);
    for (int i = 0; i < 8; i++) lvl[1][i] = 0;
    @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    chk("d1_sync_after_rst", sync1, 1);
    repeat (4) turn(1, 8'($urandom_range(15, 1)), 1'($urandom_range(1, 0)));
    check_levels(1, "rand");
    wait_sync(1);
    check_period(1, lvl[1]);

    // Instance 2: 8-bit wrap from zero.
    rst2 = 1'b1;
    @(negedge clk);
    turn(2, 8'b1, 1'b0);
    chk("d2_wrap_down", get_level(2, 0), 255);
    wait_sync(2);
    check_period(2, lvl[2]);
    turn(2, 8'b1, 1'b1);
    chk("d2_wrap_up", get_level(2, 0), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pwm_mixer_n.md
PWM_MIXER_N -- requirements
Module: pwm_mixer_n

Interface
REQ-001 Parameter NUM_CH, default 3: number of encoder/PWM channels, 1..8.
REQ-002 Parameter WIDTH, default 8: level and PWM counter width, 4..12.
REQ-003 Parameter HIST_LEN, default 8: debounce history length in cycles, 2..16.
REQ-004 Parameter SATURATE, default 1: 1 = clamp level at 0 and 2^WIDTH-1; 0 = wrap modulo 2^WIDTH.
REQ-005 Parameter STEP, default 1: level change per detent, 1..2^(WIDTH-1).
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-008 enc_a  input  NUM_CH  quadrature A per channel, asynchronous to clk.
REQ-009 enc_b  input  NUM_CH  quadrature B per channel, asynchronous to clk.
REQ-010 pwm_out  output  NUM_CH  registered PWM output per channel.
REQ-011 level_out  output  NUM_CH*WIDTH  live level per channel, channel i at bits [i*WIDTH +: WIDTH].
REQ-012 sync  output  1  one-cycle pulse at PWM period start.
REQ-013 io_oeb  output  NUM_CH+1  constant 0 (all pads driven).

Function
REQ-014 Each enc_a/enc_b bit SHALL pass a 2-flop synchroniser, then a HIST_LEN-bit shift-register debouncer: output sets to 1 when history all ones, clears to 0 when all zeros, otherwise holds.
REQ-015 On a debounced-A rising edge, level SHALL add STEP if debounced B is 0, subtract STEP if debounced B is 1, in the cycle after the edge is detected.
REQ-016 SATURATE=1: add past 2^WIDTH-1 SHALL give 2^WIDTH-1; subtract below 0 SHALL give 0.
REQ-017 SATURATE=0: add/subtract SHALL wrap modulo 2^WIDTH.
REQ-018 Debounced-B edges alone SHALL never change level.
REQ-019 One free-running WIDTH-bit period counter SHALL be shared, counting 0..2^WIDTH-1 and wrapping to 0.
REQ-020 Each channel SHALL hold a duty shadow register loaded from its level only in the cycle the counter equals 2^WIDTH-1 (glitch-free update at period boundary).
REQ-021 pwm_out[i] SHALL be registered: 1 when counter < duty_i, else 0; level 0 gives constant 0; level 2^WIDTH-1 gives high 2^WIDTH-1 of 2^WIDTH cycles.
REQ-022 sync SHALL be 1 exactly in the cycles where the counter is 0, aligned with the first cycle of the new duty.
REQ-023 Level change coincident with the shadow-load cycle: the shadow SHALL take the pre-update level; the new level applies next period.
REQ-024 Channels SHALL be fully independent; simultaneous edges on all channels SHALL all be counted.

Reset
REQ-025 While reset=0: synchronisers, debounce histories and outputs, levels, duty shadows, period counter = 0; pwm_out = 0, level_out = 0, sync = 0.
REQ-026 Reset assertion mid-period SHALL clear immediately (asynchronously); after release the counter starts at 0 and the first sync pulse occurs in the first cycle after release.

Structure
REQ-027 A shared package SHALL hold parameter range limits and the debounce/level reset constants.
REQ-028 One sub-module mixer_channel SHALL contain synchronisers, two debouncers, level register and duty shadow/comparator; top instantiates NUM_CH copies via generate plus the shared counter.

Verification
REQ-029 Defaults, reset release, no encoder activity -> all pwm_out 0, level_out 0, sync every 256 cycles.
REQ-030 Ch0: 5 clean detents forward (B=0 at A rise, each phase held >= HIST_LEN+3 cycles) -> level_out[7:0]=5; next period pwm_out[0] high 5 of 256 cycles.
REQ-031 A bouncing with 3-cycle glitches under HIST_LEN=8 -> no level change.
REQ-032 SATURATE=1: 3 reverse detents from 0 -> level 0; from 254 three forward -> 255. SATURATE=0: 1 reverse from 0 -> 255.
REQ-033 Level change in the counter=255 cycle -> current period unchanged, new duty from next sync.
REQ-034 NUM_CH=4, WIDTH=6, STEP=4: simultaneous detent on all channels -> all levels 4, period 64 cycles; reset=0 mid-period -> all outputs 0 within the same cycle.
